bus_select_encoder: RTL
=======================

Name: bus_select_encoder

Overview:
- Drive side of the datapath bus: converts the control unit's one-hot "xxxOut" strobes into the registered 5-bit `encoded` select consumed by the bus multiplexer.
- Provides registered select, valid flag and hold-on-idle behaviour.
- Detects multi-driver contention, resolves it deterministically, and keeps a sticky error plus a saturating event count for debug.
- Sits between the control unit and the bus multiplexer, one per bus.

Parameters:
- NUM_SRC, 24, number of bus sources; strobe bit index equals select code.
- IDLE_CODE, 5'd31, select code driven after reset, and while idle when HOLD_LAST=0.
- HOLD_LAST, 1, 1 = keep the last granted code while idle; 0 = drive IDLE_CODE while idle.
- CNT_W, 8, width of the contention counter.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- out_en  input  NUM_SRC  source strobes; code mapping:
  - bit23 R0Out, bit22 R1Out … bit8 R15Out
  - bit7 HIOut, bit6 LOOut, bit5 ZHighOut, bit4 ZLowOut
  - bit3 PCOut, bit2 MDROut, bit1 InPortOut, bit0 COut
- freeze  input  1  synchronous stall; all registers hold.
- clr_err  input  1  synchronous clear of `err_sticky` and `contention_cnt`.
- encoded  output  5  registered select to the bus multiplexer.
- bus_valid  output  1  registered; 1 when `encoded` reflects a source granted this cycle.
- contention  output  1  registered one-cycle pulse: more than one strobe was sampled.
- err_sticky  output  1  set on any contention; held until `clr_err` or reset.
- contention_cnt  output  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (`clr_n` low, asynchronous):
  - `encoded` = IDLE_CODE
  - `bus_valid` = 0, `contention` = 0, `err_sticky` = 0, `contention_cnt` = 0
- Reset release: first update occurs at the first rising clk with `clr_n` high.
- Latency: one cycle. Strobes sampled at edge N appear on the outputs after edge N; the bus mux sees the new source in cycle N+1.
- `freeze`=1: every register holds its value, including `contention` and the counter. This overrides all other inputs except reset.
- Exactly one strobe set at bit k:
  - `encoded` <= k, `bus_valid` <= 1, `contention` <= 0.
- No strobe set (idle):
  - `bus_valid` <= 0, `contention` <= 0.
  - `encoded` <= previous value if HOLD_LAST=1, else IDLE_CODE.
- Two or more strobes set:
  - Grant the highest set index, so R0 has priority and COut has lowest priority.
  - `encoded` <= that index, `bus_valid` <= 1, `contention` <= 1, `err_sticky` <= 1.
  - `contention_cnt` increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - ZHighOut and ZLowOut together count as contention; code 5 is granted.
- `clr_err`=1 with no contention that cycle: `err_sticky` <= 0, `contention_cnt` <= 0.
- `clr_err`=1 in the same cycle as contention: the new event wins, giving `err_sticky` = 1 and `contention_cnt` = 1.
- Strobe bits at index >= NUM_SRC do not exist. `encoded` never takes a value in NUM_SRC..30 except IDLE_CODE.
- Pure sequential logic with a combinational priority encoder in front. No latches; all outputs come directly from flops.

Test Plan:
- Reset then idle: assert `clr_n`=0 mid-cycle → outputs clear immediately with `encoded`=31 and `bus_valid`=0. Release and hold `out_en`=0 for 3 cycles → outputs unchanged.
- Single source walk: drive each one-hot bit k=0..23 for one cycle → next cycle `encoded`=k and `bus_valid`=1. Then `out_en`=0 → `encoded` holds the last value 23, `bus_valid`=0; with HOLD_LAST=0 → `encoded`=31.
- Contention: `out_en` = bit23|bit3 (R0Out+PCOut) → `encoded`=23, `contention` pulses for 1 cycle, `err_sticky`=1, `contention_cnt`=1. Next `out_en`=bit3 → `encoded`=3, `contention`=0, `err_sticky` still 1.
- Saturation and clear: 300 consecutive contention cycles → `contention_cnt`=255. `clr_err` with one strobe → count 0, sticky 0. `clr_err` with contention → count 1, sticky 1.
- Freeze: after granting 2 (MDROut), set `freeze`=1 while applying bit6 (LOOut) → `encoded` stays 2. Drop `freeze` → `encoded`=6 one cycle later.
- Reset mid-contention: assert `clr_n` during a contention cycle → the counter and sticky clear immediately and no pulse appears after release.

Source files
------------

// File: rtl/bus_select_encoder.sv
// ---------------------------------------------------------------------------
// bus_select_encoder
//
// Purpose:
//   Drive side of one datapath bus. Turns the control unit's one-hot
//   "xxxOut" strobes into the registered 5-bit select used by the bus
//   multiplexer. When several strobes are raised together, the highest index
//   wins (R0Out highest, COut lowest). The event is also flagged as a
//   one-cycle contention pulse, a sticky error and a saturating counter.
//
// Ports:
//   clk            in   rising-edge clock
//   clr_n          in   asynchronous active-low reset
//   out_en         in   [NUM_SRC] source strobes, bit index == select code
//                       (bit23 R0Out .. bit8 R15Out, bit7 HIOut, bit6 LOOut,
//                        bit5 ZHighOut, bit4 ZLowOut, bit3 PCOut, bit2 MDROut,
//                        bit1 InPortOut, bit0 COut)
//   freeze         in   synchronous stall, every register holds
//   clr_err        in   synchronous clear of err_sticky / contention_cnt
//   encoded        out  [5] registered select to the bus multiplexer
//   bus_valid      out  a source was granted on the last update
//   contention     out  one-cycle pulse, more than one strobe was sampled
//   err_sticky     out  set on any contention, held until clr_err or reset
//   contention_cnt out  [CNT_W] saturating count of contention cycles
// ---------------------------------------------------------------------------
module bus_select_encoder #(
    parameter int         NUM_SRC   = 24,
    parameter logic [4:0] IDLE_CODE = 5'd31,
    parameter int         HOLD_LAST = 1,
    parameter int         CNT_W     = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NUM_SRC-1:0] out_en,
    input  logic               freeze,
    input  logic               clr_err,
    output logic [4:0]         encoded,
    output logic               bus_valid,
    output logic               contention,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   contention_cnt
);

    localparam logic [NUM_SRC-1:0] LSB_ONE = NUM_SRC'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [4:0]         w_grant;
    logic               w_any;
    logic               w_multi;
    logic [NUM_SRC-1:0] w_lower_cleared;

    logic [4:0]         r_encoded;
    logic               r_bus_valid;
    logic               r_contention;
    logic               r_err_sticky;
    logic [CNT_W-1:0]   r_cnt;

    // Priority encoder: scanning upward lets the highest set strobe
    // overwrite any lower one, so R0Out (bit 23) ends up with top priority.
    always_comb begin
        w_grant = IDLE_CODE;
        w_any   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (out_en[i]) begin
                w_grant = i[4:0];
                w_any   = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something behind only when two
    // or more strobes are set.
    assign w_lower_cleared = out_en & (out_en - LSB_ONE);
    assign w_multi         = |w_lower_cleared;

    // Select and valid registers. While idle, the select either keeps the
    // last granted code, so the mux stays quiet, or returns to IDLE_CODE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_encoded   <= IDLE_CODE;
            r_bus_valid <= 1'b0;
        end else if (!freeze) begin
            if (w_any) begin
                r_encoded   <= w_grant;
                r_bus_valid <= 1'b1;
            end else begin
                r_bus_valid <= 1'b0;
                if (HOLD_LAST == 0) begin
                    r_encoded <= IDLE_CODE;
                end
            end
        end
    end

    // Contention bookkeeping. A new contention event takes precedence over
    // clr_err in the same cycle, so the event that caused the clear request
    // is never lost: sticky re-sets and the count restarts at one.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_contention <= 1'b0;
            r_err_sticky <= 1'b0;
            r_cnt        <= '0;
        end else if (!freeze) begin
            r_contention <= w_multi;
            if (w_multi) begin
                r_err_sticky <= 1'b1;
                if (clr_err) begin
                    r_cnt <= CNT_ONE;
                end else if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else if (clr_err) begin
                r_err_sticky <= 1'b0;
                r_cnt        <= '0;
            end
        end
    end

    assign encoded        = r_encoded;
    assign bus_valid      = r_bus_valid;
    assign contention     = r_contention;
    assign err_sticky     = r_err_sticky;
    assign contention_cnt = r_cnt;

endmodule
